// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MW-stage CPU port and a DMA engine, with bounded DMA burst locking and starvation relief.
// Optional macro ARB_STATS_EN enables the stall/beat statistic counters; otherwise the stat ports are tied to 0.
module dmem_arbiter #(
    parameter int BURST_MAX    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_burst,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stat_cpu_stalls,
    output logic [31:0] stat_dma_beats
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ARB      = 1'b0,
        DMA_LOCK = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            starved;
    logic            lock_beat;

    assign starved   = (starve_q == SW'(STARVE_LIMIT));
    assign lock_beat = (state_q == DMA_LOCK) && dma_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    // A lock cycle without dma_req falls back to plain ARB evaluation
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        if (lock_beat) begin
            starve_d = '0;
            if (!dma_burst || (beat_q + BW'(1)) == BW'(BURST_MAX)) begin
                state_d = ARB;
                beat_d  = '0;
            end else begin
                beat_d  = beat_q + BW'(1);
            end
        end else begin
            state_d = ARB;
            beat_d  = '0;
            if (dma_gnt) begin
                starve_d = '0;
                if (dma_burst) begin
                    state_d = DMA_LOCK;
                    beat_d  = BW'(1);
                end
            end else if (cpu_gnt && dma_req) begin
                starve_d = starved ? starve_q : starve_q + SW'(1);
            end else if (!dma_req) begin
                starve_d = '0;
            end
        end
    end

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (lock_beat || (dma_req && (!cpu_req || starved))) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        cpu_stall = cpu_req && !cpu_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = !dma_we;
            mem_write = dma_we;
        end
        cpu_rdata = cpu_gnt ? mem_rdata : '0;
        dma_rdata = dma_gnt ? mem_rdata : '0;
    end

`ifdef ARB_STATS_EN
    logic [31:0] stalls_q;
    logic [31:0] beats_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stalls_q <= '0;
            beats_q  <= '0;
        end else begin
            if (cpu_stall) stalls_q <= stalls_q + 32'd1;
            if (dma_gnt)   beats_q  <= beats_q + 32'd1;
        end
    end

    assign stat_cpu_stalls = stalls_q;
    assign stat_dma_beats  = beats_q;
`else
    assign stat_cpu_stalls = '0;
    assign stat_dma_beats  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model queues expected outputs per driven cycle, a monitor pops and compares.
module tb_dmem_arbiter;

    localparam int BURST_MAX    = 8;
    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_burst, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_stall, dma_gnt, mem_read, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] stat_cpu_stalls, stat_dma_beats;

    dmem_arbiter #(.BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_burst(dma_burst), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .stat_cpu_stalls(stat_cpu_stalls), .stat_dma_beats(stat_dma_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory the arbiter fronts: combinational read, write at the edge
    logic [31:0] ram [0:255];
    logic [31:0] exp_ram [0:255];
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        logic        cpu_gnt, cpu_stall, dma_gnt, mem_read, mem_write, stats_valid;
        logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, stalls, beats;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    bit   m_lock;
    int   m_beats, m_starve;
    bit   m_stats_valid;
    logic [31:0] m_stalls, m_dbeats;

    // last sampled DUT outputs, for scenario-level checks
    logic        s_cpu_gnt, s_dma_gnt, s_cpu_stall;
    logic [31:0] s_cpu_rdata, s_stalls, s_dbeats;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_push();
        exp_t e;
        bit   dwin, cwin;
        e.stats_valid = m_stats_valid;
`ifdef ARB_STATS_EN
        e.stalls = m_stalls;
        e.beats  = m_dbeats;
`else
        e.stalls = 32'd0;
        e.beats  = 32'd0;
`endif
        dwin = !reset && dma_req && (m_lock || !cpu_req || m_starve == STARVE_LIMIT);
        cwin = !reset && !dwin && cpu_req;
        e.cpu_gnt   = cwin;
        e.dma_gnt   = dwin;
        e.cpu_stall = cpu_req && !cwin;
        e.mem_addr  = cwin ? cpu_addr : dwin ? dma_addr : 32'd0;
        e.mem_wdata = cwin ? cpu_wdata : dwin ? dma_wdata : 32'd0;
        e.mem_write = (cwin && cpu_we) || (dwin && dma_we);
        e.mem_read  = (cwin && !cpu_we) || (dwin && !dma_we);
        e.cpu_rdata = cwin ? exp_ram[cpu_addr[9:2]] : 32'd0;
        e.dma_rdata = dwin ? exp_ram[dma_addr[9:2]] : 32'd0;
        sb.push_back(e);
        if (e.mem_write) exp_ram[e.mem_addr[9:2]] = e.mem_wdata;
        if (reset) begin
            m_lock = 0; m_beats = 0; m_starve = 0;
            m_stalls = 0; m_dbeats = 0; m_stats_valid = 1;
        end else begin
            if (e.cpu_stall) m_stalls = m_stalls + 1;
            if (dwin) m_dbeats = m_dbeats + 1;
            if (dwin) begin
                m_starve = 0;
                if (m_lock) begin
                    m_beats++;
                    if (!dma_burst || m_beats == BURST_MAX) begin m_lock = 0; m_beats = 0; end
                end else if (dma_burst) begin
                    m_lock = 1; m_beats = 1;
                end
            end else begin
                m_lock = 0; m_beats = 0;
                if (cwin && dma_req) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
                else if (!dma_req) m_starve = 0;
            end
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cpu_gnt",   32'(cpu_gnt),   32'(e.cpu_gnt));
            check("cpu_stall", 32'(cpu_stall), 32'(e.cpu_stall));
            check("dma_gnt",   32'(dma_gnt),   32'(e.dma_gnt));
            check("mem_read",  32'(mem_read),  32'(e.mem_read));
            check("mem_write", 32'(mem_write), 32'(e.mem_write));
            check("mem_addr",  mem_addr,  e.mem_addr);
            check("mem_wdata", mem_wdata, e.mem_wdata);
            check("cpu_rdata", cpu_rdata, e.cpu_rdata);
            check("dma_rdata", dma_rdata, e.dma_rdata);
            if (e.stats_valid) begin
                check("stat_cpu_stalls", stat_cpu_stalls, e.stalls);
                check("stat_dma_beats",  stat_dma_beats,  e.beats);
            end
            s_cpu_gnt = cpu_gnt; s_dma_gnt = dma_gnt; s_cpu_stall = cpu_stall;
            s_cpu_rdata = cpu_rdata; s_stalls = stat_cpu_stalls; s_dbeats = stat_dma_beats;
        end
    end

    task automatic step(input logic rst, input logic creq, input logic cwe, input logic [31:0] caddr,
                        input logic [31:0] cwd, input logic dreq, input logic dburst, input logic dwe,
                        input logic [31:0] daddr, input logic [31:0] dwd);
        @(negedge clk);
        reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_burst = dburst; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        model_push();
        #4;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [5:0] pat;
        int         dcount, run, maxrun;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5;
            exp_ram[i] = ram[i];
        end
        m_lock = 0; m_beats = 0; m_starve = 0; m_stats_valid = 0; m_stalls = 0; m_dbeats = 0;
        do_reset();
        do_reset();

        // CPU-only write then read back
        step(1'b0, 1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1);
        check("s1_wr_gnt", 32'(s_cpu_gnt), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h2);
        check("s1_rd_data", s_cpu_rdata, 32'hDEAD_BEEF);
        check("s1_rd_stall", 32'(s_cpu_stall), 32'd0);

        // Conflict with starvation relief, no burst
        do_reset();
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'(c * 4), 32'h0, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(c * 4), 32'hC0DE_0000 + 32'(c));
            pat[c] = s_dma_gnt;
        end
        check("s2_dma_pattern", 32'(pat), 32'h10);

        // Burst under continuous CPU traffic, reaching the beat limit
        do_reset();
        dcount = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 13; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200 + 32'(c * 4), 32'hB000_0000 + 32'(c));
            if (s_dma_gnt) begin dcount++; run++; if (run > maxrun) maxrun = run; end
            else run = 0;
        end
        check("s3_dma_beats", 32'(dcount), 32'(BURST_MAX));
        check("s3_max_run", 32'(maxrun), 32'(BURST_MAX));
        check("s3_cpu_after", 32'(s_cpu_gnt), 32'd1);
`ifdef ARB_STATS_EN
        check("s3_stat_beats", s_dbeats, 32'd8);
        check("s3_stat_stalls", s_stalls, 32'd8);
`else
        check("s3_stat_beats", s_dbeats, 32'd0);
        check("s3_stat_stalls", s_stalls, 32'd0);
`endif

        // Early burst end, then lock released by dma_req dropping
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h304, 32'h1111_1111, 1'b1, 1'b1, 1'b0, 32'h304, 32'h0);
        check("s4_beat2_stall", 32'(s_cpu_stall), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h308, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 32'h308, 32'h3333_3333);
        check("s4_beat3_gnt", 32'(s_dma_gnt), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h308, 32'h0, 1'b1, 1'b1, 1'b0, 32'h30C, 32'h0);
        check("s4_cpu_next", 32'(s_cpu_gnt), 32'd1);
        check("s4_cpu_rd", s_cpu_rdata, 32'h3333_3333);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h310, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h314, 32'h4444_4444, 1'b0, 1'b1, 1'b1, 32'h318, 32'h5555_5555);
        check("s4_drop_cpu", 32'(s_cpu_gnt), 32'd1);

        // Reset on beat 5 of a burst
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
        for (int c = 0; c < 3; c++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h404 + 32'(c * 4), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h410, 32'h6666_6666);
        check("s5_rst_dma", 32'(s_dma_gnt), 32'd0);
        check("s5_rst_stall", 32'(s_cpu_stall), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0, 32'h414, 32'h0);
        check("s5_post_cpu", 32'(s_cpu_gnt), 32'd1);

        // Random mixed traffic against the model
        for (int c = 0; c < 80; c++)
            step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), {22'd0, 8'($urandom), 2'b00},
                 $urandom, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                 {22'd0, 8'($urandom), 2'b00}, $urandom);

        @(negedge clk);
        #4;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_mem port between two requesters: the pipeline's memory/writeback (MW) stage (CPU) and a DMA/test-loader engine (DMA).
- CPU has default priority. DMA may lock the port for bounded bursts.
- A starvation counter guarantees DMA progress under continuous CPU traffic.
- Drives a stall to the pipeline whenever the CPU request is not granted.

Parameters:
- BURST_MAX, 8, max DMA beats per locked burst, including the first beat (>=2).
- STARVE_LIMIT, 4, consecutive CPU-won conflict cycles after which DMA wins the next conflict (>=1).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  MW stage needs memory (MemRead or MemWrite)
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; pipeline holds
- cpu_rdata  out  32  mem_rdata when cpu_gnt, else 0
- dma_req  in  1  DMA beat request
- dma_burst  in  1  DMA wants lock beyond this beat
- dma_we, dma_addr, dma_wdata  in  1/32/32  as CPU equivalents
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  32  mem_rdata when dma_gnt, else 0
- mem_addr, mem_wdata  out  32/32  to data_mem, muxed from granted side, 0 if none
- mem_read, mem_write  out  1/1  to data_mem, 0 if no grant
- mem_rdata  in  32  data_mem combinational read data
- stat_cpu_stalls  out  32  see Optional Feature
- stat_dma_beats  out  32  see Optional Feature

Behaviour:
- Grants and mem_* are combinational from state and requests. Read data returns in the same cycle as the grant. Writes commit at the edge ending the granted cycle. Latency 0 when granted.
- At most one grant per cycle. A grant is only asserted for an asserted req.
- State: FSM {ARB, DMA_LOCK}, beat_cnt [clog2(BURST_MAX+1)-1:0], starve_cnt [clog2(STARVE_LIMIT+1)-1:0].
- While reset is high:
  - All grants, mem_read, mem_write, cpu_rdata, dma_rdata and mem_addr/mem_wdata are 0.
  - cpu_stall = cpu_req.
  - Next state ARB, beat_cnt=0, starve_cnt=0, stats=0.
  - Reset mid-burst abandons the burst; no beat is granted in the reset cycle.
- ARB:
  - DMA wins if dma_req & (~cpu_req | starve_cnt==STARVE_LIMIT). Otherwise CPU wins if cpu_req.
  - On a DMA grant: starve_cnt<=0. If dma_burst, then next DMA_LOCK and beat_cnt<=1; else stay ARB.
  - On a CPU grant with dma_req high: starve_cnt<=starve_cnt+1, saturating at STARVE_LIMIT.
  - With dma_req low, starve_cnt<=0.
- DMA_LOCK:
  - If dma_req: DMA granted, CPU stalled regardless of cpu_req, starve_cnt<=0, beat_cnt<=beat_cnt+1.
    - If ~dma_burst or beat_cnt+1==BURST_MAX, then next ARB and beat_cnt<=0. Else stay.
  - If ~dma_req: the cycle is evaluated exactly as ARB (CPU may be granted that cycle), and next state is taken from the ARB rules.
- Burst bound: a locked burst never exceeds BURST_MAX consecutive DMA grants. After the final beat, the next cycle is ARB with starve_cnt=0, so a pending CPU request wins.
- Simultaneous cpu_req & dma_req in ARB with starve_cnt<STARVE_LIMIT: CPU wins.
- Inputs from the non-granted side never affect mem_* outputs.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_cpu_stalls increments every cycle cpu_stall=1 while reset is low.
  - stat_dma_beats increments on every dma_gnt.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred.

Test Plan:
1. CPU-only traffic: cpu_req=1, write 0x10010000<=0xDEADBEEF, then read the same address -> cpu_gnt=1 both cycles, cpu_stall=0, cpu_rdata=0xDEADBEEF, dma_gnt=0.
2. Conflict, starvation: cpu_req and dma_req held high from cycle 0 -> CPU granted cycles 0-3, DMA granted cycle 4 (STARVE_LIMIT=4), CPU granted cycle 5; cpu_stall=1 only in cycle 4.
3. DMA burst with dma_burst=1 held and cpu_req=1 held -> exactly 8 consecutive dma_gnt, cpu_stall=1 for those 8 cycles, then cpu_gnt=1 on cycle 9.
4. Early burst end: dma_burst drops on beat 3 -> beat 3 granted, FSM returns to ARB, pending CPU granted next cycle; dma_req dropping mid-lock hands the same cycle to the CPU.
5. Reset asserted during beat 5 of a burst -> no grants in the reset cycle, ARB afterwards, counters 0, first post-reset conflict granted to CPU.
6. ARB_STATS_EN defined: run scenario 3 -> stat_dma_beats=8, stat_cpu_stalls=8. Undefined: both read 0.
